// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers for the round-robin arbiter family.
package arb_pkg;

    localparam int unsigned ARB_MAX_N     = 64;
    localparam int unsigned ARB_MAX_IDX_W = 6;

    function automatic int unsigned ARB_IDX_W(input int unsigned n);
        return $clog2(n);
    endfunction

    // Vectors narrower than ARB_MAX_N are zero-extended by the caller.
    function automatic logic [ARB_MAX_IDX_W-1:0] onehot2bin(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_MAX_IDX_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) b = b | ARB_MAX_IDX_W'(i);
        end
        return b;
    endfunction

    typedef struct packed {
        logic [ARB_MAX_N-1:0]     gnt;
        logic [ARB_MAX_IDX_W-1:0] idx;
        logic                     valid;
    } arb_gnt_t;

endpackage

// File: rtl/prefix_or.sv
// Exclusive prefix OR: pre[i] is the OR of all x bits strictly below i.
module prefix_or #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] pre
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        pre = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pre[i] = acc;
            acc    = acc | x[i];
        end
    end

endmodule

// File: rtl/rr_prefix_arbiter.sv
// Registered work-conserving round-robin arbiter with bounded grant locking.
module rr_prefix_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned LOCK_EN  = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ-1:0]                   lock,
    input  logic                               gnt_ready,
    output logic [N_REQ-1:0]                   gnt,
    output logic                               gnt_valid,
    output logic [ARB_IDX_W(N_REQ)-1:0]        gnt_idx
);

    localparam int unsigned IDX_W  = ARB_IDX_W(N_REQ);
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD > 1) ? HOLD_W'(MAX_HOLD - 1) : '0;

    logic [N_REQ-1:0]  gnt_q;
    logic              valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [HOLD_W-1:0] hold_q;

    logic              arb_evt;
    logic              accept;
    logic              keep;
    logic [IDX_W-1:0]  ptr_eff;
    logic [N_REQ-1:0]  mask;
    logic [N_REQ-1:0]  masked;
    logic [N_REQ-1:0]  sel;
    logic [N_REQ-1:0]  pre;
    logic [N_REQ-1:0]  winner;

    always_comb begin
        arb_evt = !valid_q || gnt_ready;
        accept  = valid_q && gnt_ready;
        keep    = accept && (LOCK_EN != 0) && lock[idx_q] && req[idx_q]
                  && ((MAX_HOLD == 0) || (hold_q < HOLD_LIM));
        // The owner being released this edge already moves the priority pointer.
        ptr_eff = accept ? idx_q : ptr_q;
        mask    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mask[i] = (IDX_W'(i) > ptr_eff);
        end
        masked  = req & mask;
        sel     = (|masked) ? masked : req;
        winner  = sel & ~pre;
    end

    prefix_or #(.W(N_REQ)) u_prefix_or (
        .x   (sel),
        .pre (pre)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
        end else if (arb_evt) begin
            if (keep) begin
                hold_q <= hold_q + 1'b1;
            end else begin
                ptr_q   <= ptr_eff;
                hold_q  <= '0;
                gnt_q   <= winner;
                valid_q <= |winner;
                idx_q   <= IDX_W'(onehot2bin(ARB_MAX_N'(winner)));
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_prefix_arbiter.sv
// Scoreboard bench: two arbiters (locking on / off) against a circular-search reference model.
module tb_rr_prefix_arbiter;

    localparam int N  = 8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] lock;
    logic       gnt_ready;

    logic [7:0] gnt_a       [2];
    logic       gnt_valid_a [2];
    logic [2:0] gnt_idx_a   [2];

    always #5 clk = ~clk;

    rr_prefix_arbiter #(.N_REQ(N), .LOCK_EN(1), .MAX_HOLD(MH)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .gnt_ready (gnt_ready),
        .gnt       (gnt_a[0]),
        .gnt_valid (gnt_valid_a[0]),
        .gnt_idx   (gnt_idx_a[0])
    );

    rr_prefix_arbiter #(.N_REQ(N), .LOCK_EN(0), .MAX_HOLD(MH)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .gnt_ready (gnt_ready),
        .gnt       (gnt_a[1]),
        .gnt_valid (gnt_valid_a[1]),
        .gnt_idx   (gnt_idx_a[1])
    );

    typedef struct {
        bit v;
        int idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_err = 0;

    bit m_v    [2];
    int m_idx  [2];
    int m_ptr  [2];
    int m_hold [2];

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_v[d]    = 1'b0;
            m_idx[d]  = 0;
            m_ptr[d]  = N - 1;
            m_hold[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference: search circularly starting just after the last accepted owner.
    task automatic model_step(input int d, input bit lock_en);
        bit   acc;
        int   f;
        exp_t e;
        if (m_v[d] && !gnt_ready) return;
        acc = m_v[d] && gnt_ready;
        if (acc && lock_en && lock[m_idx[d]] && req[m_idx[d]] && (m_hold[d] < MH - 1)) begin
            m_hold[d]++;
        end else begin
            if (acc) m_ptr[d] = m_idx[d];
            m_hold[d] = 0;
            f = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr[d] + k) % N;
                if (f < 0 && req[j]) f = j;
            end
            m_v[d]   = (f >= 0);
            m_idx[d] = (f >= 0) ? f : 0;
        end
        e.v   = m_v[d];
        e.idx = m_idx[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called at posedge+1; a granted-but-unaccepted owner keeps its request.
    task automatic cycle(input logic [7:0] r, input logic [7:0] l, input bit rdy);
        logic [7:0] rr;
        rr = r;
        if (!rdy) begin
            for (int d = 0; d < 2; d++) if (m_v[d]) rr[m_idx[d]] = 1'b1;
        end
        req       = rr;
        lock      = l;
        gnt_ready = rdy;
        @(posedge clk);
        if (rst_n) begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
        #1;
    endtask

    task automatic idle();
        repeat (2) cycle(8'h00, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_valid", d, 64'(gnt_valid_a[d]), 64'd0);
            chk("async_rst_gnt",   d, 64'(gnt_a[d]),       64'd0);
            chk("async_rst_idx",   d, 64'(gnt_idx_a[d]),   64'd0);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst_n && gnt_valid_a[0] && !gnt_ready)
            assert (req[gnt_idx_a[0]]) else $error("FAIL proto_req_drop dut0 idx %0d", gnt_idx_a[0]);
        if (rst_n && gnt_valid_a[1] && !gnt_ready)
            assert (req[gnt_idx_a[1]]) else $error("FAIL proto_req_drop dut1 idx %0d", gnt_idx_a[1]);
    end

    bit         prev_v [2];
    bit         prev_rdy    = 1'b0;
    bit         prev_rst_lo = 1'b1;
    logic [7:0] held_g [2];
    logic [2:0] held_i [2];

    task automatic mon(input int d);
        exp_t e;
        bit   empty;
        if (!rst_n || prev_rst_lo) begin
            chk("reset_valid", d, 64'(gnt_valid_a[d]), 64'd0);
            chk("reset_gnt",   d, 64'(gnt_a[d]),       64'd0);
            chk("reset_idx",   d, 64'(gnt_idx_a[d]),   64'd0);
            prev_v[d] = 1'b0;
            return;
        end
        if (!prev_v[d] || prev_rdy) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty dut%0d: got valid %0d, expected a queued grant at %0t",
                         d, gnt_valid_a[d], $time);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("valid", d, 64'(gnt_valid_a[d]), 64'(e.v));
                chk("gnt",   d, 64'(gnt_a[d]),       e.v ? (64'd1 << e.idx) : 64'd0);
                chk("idx",   d, 64'(gnt_idx_a[d]),   64'(e.idx));
            end
        end else begin
            chk("hold_valid", d, 64'(gnt_valid_a[d]), 64'd1);
            chk("hold_gnt",   d, 64'(gnt_a[d]),       64'(held_g[d]));
            chk("hold_idx",   d, 64'(gnt_idx_a[d]),   64'(held_i[d]));
        end
        prev_v[d] = gnt_valid_a[d];
        held_g[d] = gnt_a[d];
        held_i[d] = gnt_idx_a[d];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        prev_rdy    = gnt_ready;
        prev_rst_lo = !rst_n;
    end

    initial begin
        logic [7:0] r;
        logic [7:0] l;
        bit         rdy;
        rst_n     = 1'b0;
        req       = '0;
        lock      = '0;
        gnt_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (6)  cycle(8'hA0, 8'h00, 1'b1);
        idle();
        repeat (16) cycle(8'hFF, 8'h00, 1'b1);
        idle();
        repeat (5)  cycle(8'h03, 8'h00, 1'b0);
        cycle(8'h03, 8'h00, 1'b1);
        cycle(8'h03, 8'h00, 1'b0);
        idle();
        repeat (12) cycle(8'h06, 8'h02, 1'b1);
        idle();

        cycle(8'h08, 8'h00, 1'b1);
        cycle(8'h08, 8'h00, 1'b0);
        do_reset();
        cycle(8'h08, 8'h00, 1'b1);
        cycle(8'h00, 8'h00, 1'b1);
        do_reset();
        repeat (3) cycle(8'hFF, 8'h00, 1'b1);
        idle();

        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 4) == 0) r = r & 8'($urandom);
            l   = 8'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            if (i == 300) do_reset();
            cycle(r, l, rdy);
        end
        idle();
        #10;
        chk("sb_drain", 0, 64'(q0.size()), 64'd0);
        chk("sb_drain", 1, 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
